// File: rtl/lidar_sweep_segmenter.sv
// lidar_sweep_segmenter
//   Splits a raw LiDAR point stream (distance, angle) into angular clusters,
//   one sweep at a time, and streams up to MAX_OBJ cluster records per sweep.
//   Two cluster banks work as a ping-pong pair: one is built while the other
//   is read out.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   lidar_distance/angle/valid  point input, no backpressure
//   obj_valid/ready             record handshake
//   obj_range/angle/width       min distance, midpoint angle, angular span
//   obj_points, obj_last        point count (saturating), final record flag
//   sweep_done, sweep_dropped   pulses: bank handed to readout / sweep discarded
//   sweep_count, overflow       record count and overflow flag of bank being read
module lidar_sweep_segmenter #(
    parameter int unsigned MAX_OBJ   = 8,
    parameter int unsigned MIN_RANGE = 500,
    parameter int unsigned MAX_RANGE = 200000,
    parameter int unsigned GAP_MM    = 300,
    parameter int unsigned MAX_ASTEP = 64,
    parameter int unsigned MIN_PTS   = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] lidar_distance,
    input  logic [15:0] lidar_angle,
    input  logic        lidar_valid,
    output logic        obj_valid,
    input  logic        obj_ready,
    output logic [31:0] obj_range,
    output logic [15:0] obj_angle,
    output logic [15:0] obj_width,
    output logic [7:0]  obj_points,
    output logic        obj_last,
    output logic        sweep_done,
    output logic [3:0]  sweep_count,
    output logic        overflow,
    output logic        sweep_dropped
);

    localparam int unsigned IW = (MAX_OBJ > 1) ? $clog2(MAX_OBJ) : 1;

    typedef enum logic {RD_IDLE, RD_BUSY} rd_state_t;

    // Open-cluster tracking
    logic        last_vld;
    logic [15:0] last_angle;
    logic        c_open;
    logic [31:0] c_min, c_dlast;
    logic [15:0] c_start, c_end;
    logic [7:0]  c_cnt;
    logic        bsel;

    // Registered commit and seal requests, applied one cycle after the point
    logic        cm_v, cm_bank;
    logic [31:0] cm_range;
    logic [15:0] cm_angle, cm_width;
    logic [7:0]  cm_pts;
    logic        sl_v, sl_bank;

    // Bank tables
    logic [1:0][3:0] wr_cnt;
    logic [1:0]      ovf;
    logic [31:0] t_range [2][MAX_OBJ];
    logic [15:0] t_angle [2][MAX_OBJ];
    logic [15:0] t_width [2][MAX_OBJ];
    logic [7:0]  t_pts   [2][MAX_OBJ];

    // Readout
    rd_state_t   rd_state, rd_next;
    logic        rd_bank;
    logic [IW-1:0] rd_idx;

    logic        gated, wrap, cont, close;
    logic [31:0] d_step;
    logic [15:0] a_step, span;
    logic        build_bank;
    logic [3:0]  cm_cur, sl_cur, fin_cnt;
    logic        commit_ok, fin_ovf, handoff, rd_fire, rd_last_hit;

    always_comb begin
        gated  = (lidar_distance < MIN_RANGE) || (lidar_distance > MAX_RANGE);
        wrap   = lidar_valid && last_vld && (lidar_angle < last_angle);
        d_step = (lidar_distance >= c_dlast) ? lidar_distance - c_dlast
                                             : c_dlast - lidar_distance;
        a_step = lidar_angle - c_end;
        // The explicit !wrap guards against a modular angle step near 0/65535
        cont   = lidar_valid && c_open && !wrap && !gated &&
                 (d_step <= GAP_MM) && (a_step <= 16'(MAX_ASTEP));
        close  = lidar_valid && c_open && !cont;
        span   = c_end - c_start;
    end

    always_comb begin
        handoff     = sl_v && (rd_state == RD_IDLE);
        // A seal being handed off this cycle moves building to the other bank
        build_bank  = handoff ? ~sl_bank : bsel;
        cm_cur      = wr_cnt[cm_bank];
        sl_cur      = wr_cnt[sl_bank];
        commit_ok   = cm_v && (cm_cur < 4'(MAX_OBJ));
        // Count and overflow of the sealed bank include the commit landing this cycle
        fin_cnt     = sl_cur + {3'b0, (commit_ok && (cm_bank == sl_bank))};
        fin_ovf     = ovf[sl_bank] | (cm_v && !commit_ok && (cm_bank == sl_bank));
        rd_fire     = (rd_state == RD_BUSY) && obj_ready;
        rd_last_hit = (4'(rd_idx) == sweep_count - 4'd1);
    end

    // Point processing and cluster building
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_vld   <= 1'b0;
            last_angle <= '0;
            c_open     <= 1'b0;
            c_min      <= '0;
            c_dlast    <= '0;
            c_start    <= '0;
            c_end      <= '0;
            c_cnt      <= '0;
            bsel       <= 1'b0;
            cm_v       <= 1'b0;
            cm_bank    <= 1'b0;
            cm_range   <= '0;
            cm_angle   <= '0;
            cm_width   <= '0;
            cm_pts     <= '0;
            sl_v       <= 1'b0;
            sl_bank    <= 1'b0;
        end else begin
            cm_v <= 1'b0;
            sl_v <= 1'b0;
            if (lidar_valid) begin
                last_vld   <= 1'b1;
                last_angle <= lidar_angle;
                if (cont) begin
                    c_end   <= lidar_angle;
                    c_dlast <= lidar_distance;
                    if (lidar_distance < c_min) c_min <= lidar_distance;
                    if (c_cnt != 8'hFF) c_cnt <= c_cnt + 8'd1;
                end else begin
                    if (close && (c_cnt >= 8'(MIN_PTS))) begin
                        cm_v     <= 1'b1;
                        cm_bank  <= build_bank;
                        cm_range <= c_min;
                        cm_angle <= c_start + (span >> 1);
                        cm_width <= span;
                        cm_pts   <= c_cnt;
                    end
                    if (gated) begin
                        c_open <= 1'b0;
                    end else begin
                        c_open  <= 1'b1;
                        c_start <= lidar_angle;
                        c_end   <= lidar_angle;
                        c_min   <= lidar_distance;
                        c_dlast <= lidar_distance;
                        c_cnt   <= 8'd1;
                    end
                end
                if (wrap) begin
                    sl_v    <= 1'b1;
                    sl_bank <= build_bank;
                end
            end
            if (handoff) bsel <= ~sl_bank;
        end
    end

    always_ff @(posedge clk) begin
        if (commit_ok) begin
            t_range[cm_bank][cm_cur[IW-1:0]] <= cm_range;
            t_angle[cm_bank][cm_cur[IW-1:0]] <= cm_angle;
            t_width[cm_bank][cm_cur[IW-1:0]] <= cm_width;
            t_pts[cm_bank][cm_cur[IW-1:0]]   <= cm_pts;
        end
    end

    // Bank bookkeeping, seal/handoff and readout indexing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt        <= '0;
            ovf           <= '0;
            rd_bank       <= 1'b0;
            rd_idx        <= '0;
            sweep_done    <= 1'b0;
            sweep_dropped <= 1'b0;
            sweep_count   <= '0;
            overflow      <= 1'b0;
        end else begin
            sweep_done    <= 1'b0;
            sweep_dropped <= 1'b0;
            if (cm_v) begin
                if (commit_ok) wr_cnt[cm_bank] <= cm_cur + 4'd1;
                else           ovf[cm_bank]    <= 1'b1;
            end
            if (rd_fire) begin
                if (rd_last_hit) begin
                    wr_cnt[rd_bank] <= '0;
                    ovf[rd_bank]    <= 1'b0;
                    rd_idx          <= '0;
                end else begin
                    rd_idx <= rd_idx + 1'b1;
                end
            end
            if (sl_v) begin
                if (handoff) begin
                    sweep_done  <= 1'b1;
                    sweep_count <= fin_cnt;
                    overflow    <= fin_ovf;
                    rd_bank     <= sl_bank;
                    rd_idx      <= '0;
                end else begin
                    // Readout still busy: discard the new sweep; overrides its final commit
                    sweep_dropped   <= 1'b1;
                    wr_cnt[sl_bank] <= '0;
                    ovf[sl_bank]    <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_state <= RD_IDLE;
        else        rd_state <= rd_next;
    end

    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            RD_IDLE: if (handoff && (fin_cnt != 4'd0)) rd_next = RD_BUSY;
            RD_BUSY: if (rd_fire && rd_last_hit)       rd_next = RD_IDLE;
            default: rd_next = RD_IDLE;
        endcase
    end

    always_comb begin
        obj_valid  = 1'b0;
        obj_range  = '0;
        obj_angle  = '0;
        obj_width  = '0;
        obj_points = '0;
        obj_last   = 1'b0;
        if (rd_state == RD_BUSY) begin
            obj_valid  = 1'b1;
            obj_range  = t_range[rd_bank][rd_idx];
            obj_angle  = t_angle[rd_bank][rd_idx];
            obj_width  = t_width[rd_bank][rd_idx];
            obj_points = t_pts[rd_bank][rd_idx];
            obj_last   = rd_last_hit;
        end
    end

endmodule

// File: tb/tb_lidar_sweep_segmenter.sv
module tb_lidar_sweep_segmenter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] lidar_distance;
    logic [15:0] lidar_angle;
    logic        lidar_valid;
    logic        obj_valid;
    logic        obj_ready;
    logic [31:0] obj_range;
    logic [15:0] obj_angle;
    logic [15:0] obj_width;
    logic [7:0]  obj_points;
    logic        obj_last;
    logic        sweep_done;
    logic [3:0]  sweep_count;
    logic        overflow;
    logic        sweep_dropped;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int drop_cnt = 0;

    lidar_sweep_segmenter #(
        .MAX_OBJ(8), .MIN_RANGE(500), .MAX_RANGE(200000),
        .GAP_MM(300), .MAX_ASTEP(64), .MIN_PTS(3)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .lidar_distance(lidar_distance), .lidar_angle(lidar_angle),
        .lidar_valid(lidar_valid),
        .obj_valid(obj_valid), .obj_ready(obj_ready),
        .obj_range(obj_range), .obj_angle(obj_angle), .obj_width(obj_width),
        .obj_points(obj_points), .obj_last(obj_last),
        .sweep_done(sweep_done), .sweep_count(sweep_count),
        .overflow(overflow), .sweep_dropped(sweep_dropped)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sweep_done)    done_cnt++;
        if (sweep_dropped) drop_cnt++;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic pt(input logic [31:0] d, input logic [15:0] a);
        @(negedge clk);
        lidar_valid    = 1'b1;
        lidar_distance = d;
        lidar_angle    = a;
        @(posedge clk);
        #1 lidar_valid = 1'b0;
    endtask

    // Gated point at angle 0: closes the sweep and never opens a cluster
    task automatic wrap_pt();
        pt(32'd100, 16'd0);
    endtask

    task automatic wait_done(input string tag, input logic [31:0] cnt, input logic [31:0] ovf);
        bit found = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (sweep_done) begin
                found = 1;
                break;
            end
        end
        chk({tag, "_done"}, 32'(found), 32'd1);
        if (found) begin
            chk({tag, "_count"}, 32'(sweep_count), cnt);
            chk({tag, "_ovf"}, 32'(overflow), ovf);
        end
    endtask

    task automatic read_rec(input string tag, input logic [31:0] rng, input logic [31:0] ang,
                            input logic [31:0] wid, input logic [31:0] pts, input logic [31:0] last);
        bit found = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (obj_valid) begin
                found = 1;
                break;
            end
        end
        chk({tag, "_valid"}, 32'(found), 32'd1);
        if (found) begin
            chk({tag, "_range"}, obj_range, rng);
            chk({tag, "_angle"}, 32'(obj_angle), ang);
            chk({tag, "_width"}, 32'(obj_width), wid);
            chk({tag, "_points"}, 32'(obj_points), pts);
            chk({tag, "_last"}, 32'(obj_last), last);
            obj_ready = 1'b1;
            @(posedge clk);
            #1 obj_ready = 1'b0;
        end
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        chk({tag, "_idle"}, 32'(obj_valid), 32'd0);
    endtask

    initial begin
        int drop_before;
        int done_before;
        bit seen;

        rst_n          = 1'b0;
        lidar_valid    = 1'b0;
        lidar_distance = '0;
        lidar_angle    = '0;
        obj_ready      = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(obj_valid), 32'd0);
        chk("rst_done", 32'(sweep_done), 32'd0);
        chk("rst_count", 32'(sweep_count), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_range", obj_range, 32'd0);
        rst_n = 1'b1;

        // Basic cluster with exact handoff latency
        pt(5000, 100); pt(5100, 110); pt(4900, 120); pt(5050, 130);
        wrap_pt();
        @(negedge clk);
        chk("t1_done_n1", 32'(sweep_done), 32'd0);
        @(negedge clk);
        chk("t1_done_n2", 32'(sweep_done), 32'd1);
        chk("t1_valid_n2", 32'(obj_valid), 32'd1);
        chk("t1_count", 32'(sweep_count), 32'd1);
        read_rec("t1", 4900, 115, 30, 4, 1);
        check_idle("t1");

        // Break and MIN_PTS
        pt(5000, 100); pt(5000, 110); pt(5000, 120);
        pt(9000, 130); pt(9000, 140);
        wrap_pt();
        wait_done("t2", 1, 0);
        read_rec("t2", 5000, 110, 20, 3, 1);
        check_idle("t2");

        // Gating; first point at angle equal to the wrap angle is not a wrap
        pt(3000, 0); pt(3000, 10); pt(3000, 20);
        pt(300, 30);
        pt(3000, 40); pt(3000, 50); pt(3000, 60);
        wrap_pt();
        wait_done("t3", 2, 0);
        read_rec("t3a", 3000, 10, 20, 3, 0);
        read_rec("t3b", 3000, 50, 20, 3, 1);
        check_idle("t3");

        // Overflow: ten 3-point clusters, only eight kept
        for (int k = 0; k < 10; k++)
            for (int j = 0; j < 3; j++)
                pt(32'(2000 + 1000 * k), 16'(100 + 30 * k + 10 * j));
        wrap_pt();
        wait_done("t4", 8, 1);
        for (int k = 0; k < 8; k++)
            read_rec($sformatf("t4r%0d", k), 32'(2000 + 1000 * k), 32'(110 + 30 * k), 20, 3,
                     (k == 7) ? 32'd1 : 32'd0);
        check_idle("t4");

        // Backpressure and drop
        pt(7000, 100); pt(7000, 110); pt(7000, 120);
        pt(7000, 200); pt(7000, 210); pt(7000, 220);
        wrap_pt();
        wait_done("t5", 2, 0);
        chk("t5_hold0_range", obj_range, 32'd7000);
        pt(8000, 100);
        drop_before = drop_cnt;
        done_before = done_cnt;
        pt(8000, 110);
        chk("t5_hold1_angle", 32'(obj_angle), 32'd110);
        pt(8000, 120);
        wrap_pt();
        repeat (4) @(negedge clk);
        chk("t5_drops", 32'(drop_cnt - drop_before), 32'd1);
        chk("t5_no_done", 32'(done_cnt - done_before), 32'd0);
        chk("t5_hold2_valid", 32'(obj_valid), 32'd1);
        chk("t5_hold2_range", obj_range, 32'd7000);
        chk("t5_hold2_angle", 32'(obj_angle), 32'd110);
        chk("t5_hold2_last", 32'(obj_last), 32'd0);
        chk("t5_hold2_count", 32'(sweep_count), 32'd2);
        read_rec("t5a", 7000, 110, 20, 3, 0);
        read_rec("t5b", 7000, 210, 20, 3, 1);
        check_idle("t5");

        // Empty sweep: only gated points, including just outside both range limits
        pt(499, 100); pt(200001, 200); pt(100, 300);
        wrap_pt();
        wait_done("t6", 0, 0);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (obj_valid) seen = 1;
        end
        chk("t6_never_valid", 32'(seen), 32'd0);

        // Inclusive limits: MIN_RANGE distance, angle step == MAX_ASTEP, distance step == GAP_MM
        pt(500, 100); pt(500, 164); pt(800, 228);
        wrap_pt();
        wait_done("t7", 1, 0);
        read_rec("t7", 500, 164, 128, 3, 1);
        check_idle("t7");

        // Asynchronous reset during readout
        pt(6000, 100); pt(6000, 110); pt(6000, 120);
        wrap_pt();
        wait_done("t8", 1, 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t8_rst_valid", 32'(obj_valid), 32'd0);
        chk("t8_rst_count", 32'(sweep_count), 32'd0);
        chk("t8_rst_range", obj_range, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check_idle("t8");

        // Fresh sweep after reset builds from empty banks
        pt(6500, 100); pt(6500, 110); pt(6500, 120);
        pt(100, 90);
        wait_done("t9", 1, 0);
        read_rec("t9", 6500, 110, 20, 3, 1);
        check_idle("t9");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
